// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 decryption core: FSM states,
// round constants, S-box tables and GF(2^8) / inverse-round helper functions.
package aes_dec_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int KEY_WIDTH  = 128;
  localparam int NUM_ROUNDS = 10;
  localparam logic [3:0] ROUND_CNT_MAX = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Indexed by round number 1..10; padded so any 4-bit index is in range.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4. Row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      o[119 - 32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      o[111 - 32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      o[103 - 32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns except on the final round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [KEY_WIDTH-1:0]  round_key,
  input  logic                  last_round,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] added_s;

  // Inverse round datapath.
  always_comb begin
    added_s = inv_sub_bytes(inv_shift_rows(data_in)) ^ round_key;
    if (last_round) begin
      data_out = added_s;
    end else begin
      data_out = inv_mix_columns(added_s);
    end
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption: forward key expansion to rk10, then ten inverse
// rounds with backward round-key regeneration. Optional AES_DEC_KEY_CACHE_EN.
module aes_decrypt_core
  import aes_dec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] ciphertext_in,
  input  logic [KEY_WIDTH-1:0]  key_in,
  output logic [DATA_WIDTH-1:0] plaintext_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] data_r, pt_r, round_out_s;
  logic [KEY_WIDTH-1:0]  rk_r, rk_fwd_s, rk_prev_s, cache_rk10_s;
  logic [3:0]            cnt_r, rnd_r;
  logic                  valid_r, accept_s, cache_hit_s;

  function automatic logic [127:0] forward_expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expansion step: later words are recovered by XOR, then w0 from w3.
  function automatic logic [127:0] inverse_expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0] ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  assign rk_fwd_s      = forward_expand(rk_r, RCON[cnt_r]);
  assign rk_prev_s     = inverse_expand(rk_r, RCON[rnd_r]);
  assign ready_out     = (state_r == IDLE) && !rst;
  assign valid_out     = valid_r;
  assign plaintext_out = pt_r;

  aes_inv_round u_inv_round (
    .data_in    (data_r),
    .round_key  (rk_prev_s),
    .last_round (rnd_r == 4'd1),
    .data_out   (round_out_s)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [KEY_WIDTH-1:0] cache_key_r, cache_rk10_r;
  logic                 cache_valid_r;

  // Key cache: claimed on a miss, filled once KEXP produces rk10.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_key_r   <= 128'h0;
      cache_rk10_r  <= 128'h0;
      cache_valid_r <= 1'b0;
    end else if (accept_s && !cache_hit_s) begin
      cache_key_r   <= key_in;
      cache_valid_r <= 1'b0;
    end else if (state_r == KEXP && cnt_r == ROUND_CNT_MAX) begin
      cache_rk10_r  <= rk_fwd_s;
      cache_valid_r <= 1'b1;
    end
  end

  assign cache_hit_s  = cache_valid_r && (key_in == cache_key_r);
  assign cache_rk10_s = cache_rk10_r;
`else
  assign cache_hit_s  = 1'b0;
  assign cache_rk10_s = 128'h0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and handshake decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          accept_s = 1'b1;
          state_s  = cache_hit_s ? ROUND : KEXP;
        end else begin
          state_s = IDLE;
        end
      end
      KEXP: begin
        if (cnt_r == ROUND_CNT_MAX) state_s = ROUND;
        else                        state_s = KEXP;
      end
      ROUND: begin
        if (rnd_r == 4'd1) state_s = DONE;
        else               state_s = ROUND;
      end
      DONE: begin
        if (ready_in) state_s = IDLE;
        else          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: key expansion, inverse rounds and output capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= 128'h0;
      rk_r    <= 128'h0;
      cnt_r   <= 4'd0;
      rnd_r   <= 4'd0;
      pt_r    <= 128'h0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (cache_hit_s) begin
              data_r <= ciphertext_in ^ cache_rk10_s;
              rk_r   <= cache_rk10_s;
              rnd_r  <= ROUND_CNT_MAX;
            end else begin
              data_r <= ciphertext_in;
              rk_r   <= key_in;
              cnt_r  <= 4'd1;
            end
          end
        end
        KEXP: begin
          rk_r  <= rk_fwd_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == ROUND_CNT_MAX) begin
            data_r <= data_r ^ rk_fwd_s;
            rnd_r  <= ROUND_CNT_MAX;
          end
        end
        ROUND: begin
          data_r <= round_out_s;
          rk_r   <= rk_prev_s;
          rnd_r  <= rnd_r - 4'd1;
          if (rnd_r == 4'd1) begin
            pt_r    <= round_out_s;
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (ready_in) valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed-vector bench for aes_decrypt_core: known-answer blocks, latency,
// backpressure, mid-run reset, key reuse and back-to-back streaming.
module tb_aes_decrypt_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [127:0] ciphertext_in = 128'h0;
  logic [127:0] key_in = 128'h0;
  logic [127:0] plaintext_out;
  logic         valid_out;
  logic         ready_in = 1'b1;

  int n_vec = 0;
  int n_err = 0;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] S1_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] S1_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] S2_CT  = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] S2_PT  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  // Bench-side model of the optional key cache.
  logic [127:0] m_key = 128'h0;
  bit           m_valid = 1'b0;

  aes_decrypt_core dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .ciphertext_in (ciphertext_in),
    .key_in        (key_in),
    .plaintext_out (plaintext_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [127:0] key, output int lat);
    if (CACHE_EN && m_valid && key == m_key) begin
      lat = 10;
    end else begin
      lat     = 20;
      m_key   = key;
      m_valid = 1'b1;
    end
  endtask

  task automatic accept_block(input logic [127:0] key, input logic [127:0] ct);
    int w = 0;
    while (!ready_out && w < 60) begin
      tick();
      w++;
    end
    key_in        = key;
    ciphertext_in = ct;
    valid_in      = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (valid_out) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (ready_out !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_out); end
    n_vec++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_vec++;
    if (plaintext_out !== 128'h0) begin n_err++; $display("FAIL reset_pt: got %h want 0", plaintext_out); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (ready_out !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_fips_c1();
    int lat, k;
    predict(C1_KEY, lat);
    accept_block(C1_KEY, C1_CT);
    wait_valid(k);
    n_vec++;
    if (k !== lat) begin n_err++; $display("FAIL c1_latency: got %0d want %0d", k, lat); end
    n_vec++;
    if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL c1_pt: got %h want %h", plaintext_out, C1_PT); end
    tick();
    n_vec++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_err++; $display("FAIL c1_handshake: got valid=%b ready=%b want 0/1", valid_out, ready_out);
    end
  endtask

  task automatic test_fips_b();
    int lat, k;
    predict(B_KEY, lat);
    accept_block(B_KEY, B_CT);
    repeat (10) tick();
    n_vec++;
    if (dut.rk_r !== B_RK10) begin n_err++; $display("FAIL b_rk10: got %h want %h", dut.rk_r, B_RK10); end
    wait_valid(k);
    if (k != 0) k = k + 10;
    n_vec++;
    if (k !== lat) begin n_err++; $display("FAIL b_latency: got %0d want %0d", k, lat); end
    n_vec++;
    if (plaintext_out !== B_PT) begin n_err++; $display("FAIL b_pt: got %h want %h", plaintext_out, B_PT); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, k, seen;
    ready_in = 1'b0;
    predict(C1_KEY, lat);
    accept_block(C1_KEY, C1_CT);
    wait_valid(k);
    n_vec++;
    if (k !== lat) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", k, lat); end
    for (int i = 0; i < 15; i++) begin
      valid_in      = (i % 2 == 0);
      ciphertext_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_in        = B_KEY;
      tick();
      n_vec++;
      if (valid_out !== 1'b1 || plaintext_out !== C1_PT) begin
        n_err++; $display("FAIL bp_hold[%0d]: got valid=%b pt=%h want 1 %h", i, valid_out, plaintext_out, C1_PT);
      end
      n_vec++;
      if (ready_out !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, ready_out); end
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    n_vec++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", valid_out, ready_out);
    end
    seen = 0;
    repeat (25) begin
      tick();
      if (valid_out) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL bp_no_queue: got %0d outputs want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat, k, seen;
    predict(C1_KEY, lat);
    accept_block(C1_KEY, C1_CT);
    repeat (17) tick();
    rst = 1'b1;
    tick();
    m_valid = 1'b0;
    n_vec++;
    if (valid_out !== 1'b0 || plaintext_out !== 128'h0 || ready_out !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_state: got valid=%b pt=%h ready=%b want 0/0/0", valid_out, plaintext_out, ready_out);
    end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      tick();
      if (valid_out) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL mid_reset_discard: got %0d outputs want 0", seen); end
    predict(C1_KEY, lat);
    accept_block(C1_KEY, C1_CT);
    wait_valid(k);
    n_vec++;
    if (k !== 20) begin n_err++; $display("FAIL mid_reset_latency: got %0d want 20", k); end
    n_vec++;
    if (plaintext_out !== C1_PT) begin n_err++; $display("FAIL mid_reset_pt: got %h want %h", plaintext_out, C1_PT); end
    tick();
  endtask

  task automatic test_key_reuse();
    logic [127:0] keys [3];
    logic [127:0] cts  [3];
    logic [127:0] pts  [3];
    int lat, k;
    keys = '{C1_KEY, C1_KEY, B_KEY};
    cts  = '{C1_CT, C1_CT, B_CT};
    pts  = '{C1_PT, C1_PT, B_PT};
    for (int i = 0; i < 3; i++) begin
      predict(keys[i], lat);
      accept_block(keys[i], cts[i]);
      wait_valid(k);
      n_vec++;
      if (k !== lat) begin n_err++; $display("FAIL reuse_latency[%0d]: got %0d want %0d", i, k, lat); end
      n_vec++;
      if (plaintext_out !== pts[i]) begin n_err++; $display("FAIL reuse_pt[%0d]: got %h want %h", i, plaintext_out, pts[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [4];
    logic [127:0] cts  [4];
    logic [127:0] pts  [4];
    int lats [4];
    int acc  [4];
    int na, no;
    bit will;
    keys = '{C1_KEY, B_KEY, B_KEY, B_KEY};
    cts  = '{C1_CT, B_CT, S1_CT, S2_CT};
    pts  = '{C1_PT, B_PT, S1_PT, S2_PT};
    for (int i = 0; i < 4; i++) begin
      predict(keys[i], lats[i]);
      acc[i] = 0;
    end
    na = 0;
    no = 0;
    ready_in      = 1'b1;
    key_in        = keys[0];
    ciphertext_in = cts[0];
    valid_in      = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      will = ready_out && valid_in;
      tick();
      if (will) begin
        acc[na] = c;
        na++;
        if (na < 4) begin
          key_in        = keys[na];
          ciphertext_in = cts[na];
        end else begin
          valid_in = 1'b0;
        end
      end
      if (valid_out) begin
        if (no < 4) begin
          n_vec++;
          if (plaintext_out !== pts[no]) begin n_err++; $display("FAIL stream_pt[%0d]: got %h want %h", no, plaintext_out, pts[no]); end
        end
        no++;
      end
      if (no == 4) break;
    end
    valid_in = 1'b0;
    n_vec++;
    if (no !== 4) begin n_err++; $display("FAIL stream_count: got %0d outputs want 4", no); end
    for (int i = 1; i < 4; i++) begin
      n_vec++;
      if (acc[i] - acc[i-1] !== lats[i-1] + 2) begin
        n_err++; $display("FAIL stream_spacing[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], lats[i-1] + 2);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_reset_mid();
    test_key_reuse();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
